// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared constants and width helper for the dff_pipe slice.
package dff_pipe_pkg;

  // Width and saturation ceiling of the q-change counter.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Bits needed to encode the values 0..n-1, never less than one bit.
  // Fill uses clog2_w(DEPTH+1) so that the value DEPTH itself fits;
  // the divider uses clog2_w(DIV) for its 0..DIV-1 count.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: free-running 0..DIV-1 counter producing a one-cycle advance
// strobe. The strobe is a clock enable, never a derived clock.
module clk_en_div
  import dff_pipe_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic my_clk,
  input  logic rst_n,
  input  logic sclr,
  output logic tick
);

  localparam int CW = clog2_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  // Count 0..DIV-1 and wrap; sclr restarts the sequence from zero.
  // With DIV=1, LAST is zero, so the count never moves and tick stays high.
  always_ff @(posedge my_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (sclr) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Strobe is high for exactly the cycle in which the count sits at its
  // last value. This makes the first strobe after reset or clear arrive
  // DIV-1 edges later.
  assign tick = (count_reg == LAST);

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage data/valid shift pipeline that advances only on the
// divider strobe. It also tracks the number of valid stages and counts,
// with saturation, how often the output word changes.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 2
) (
  input  logic                          my_clk,
  input  logic                          rst_n,
  input  logic                          sclr,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic                          tick,
  output logic [clog2_w(DEPTH+1)-1:0]   fill,
  output logic [CNT_W-1:0]              chg_cnt
);

  localparam int FW = clog2_w(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_reg;
  logic [DEPTH-1:0][WIDTH-1:0] data_next;
  logic [DEPTH-1:0]            valid_reg;
  logic [DEPTH-1:0]            valid_next;
  logic [FW-1:0]               fill_reg;
  logic [FW-1:0]               fill_next;
  logic [CNT_W-1:0]            chg_cnt_reg;
  logic [CNT_W-1:0]            chg_cnt_next;
  logic                        tick_w;

  clk_en_div #(
    .DIV (DIV)
  ) u_div (
    .my_clk (my_clk),
    .rst_n  (rst_n),
    .sclr   (sclr),
    .tick   (tick_w)
  );

  // Candidate contents of each stage if the pipe advances this cycle.
  // Stage 0 takes the input. An invalid input becomes an all-zero bubble,
  // so no stale data can leak out of the last stage.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = d_valid;
        assign data_next[gi]  = d_valid ? d : '0;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign data_next[gi]  = data_reg[gi-1];
      end
    end
  endgenerate

  // Population count of the post-shift valid flags. Fill is registered
  // alongside the shift, so it always matches the stage contents.
  always_comb begin
    fill_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_next = fill_next + FW'(valid_next[i]);
    end
  end

  // Bump the change counter when the word about to reach q differs from
  // the word currently on q, and stop at the ceiling.
  always_comb begin
    chg_cnt_next = chg_cnt_reg;
    if ((data_next[DEPTH-1] != data_reg[DEPTH-1]) && (chg_cnt_reg != CNT_MAX)) begin
      chg_cnt_next = chg_cnt_reg + CNT_W'(1);
    end
  end

  // Pipeline state update. Clear takes precedence over the strobe, and no
  // register moves without the strobe. Every register shares one update
  // condition, so a reset or clear can never expose a partial shift.
  always_ff @(posedge my_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg    <= '0;
      valid_reg   <= '0;
      fill_reg    <= '0;
      chg_cnt_reg <= '0;
    end else if (sclr) begin
      data_reg    <= '0;
      valid_reg   <= '0;
      fill_reg    <= '0;
      chg_cnt_reg <= '0;
    end else if (tick_w) begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      fill_reg    <= fill_next;
      chg_cnt_reg <= chg_cnt_next;
    end
  end

  // The outputs come straight from the last stage and the status
  // registers, with no logic in between.
  assign q       = data_reg[DEPTH-1];
  assign q_valid = valid_reg[DEPTH-1];
  assign fill    = fill_reg;
  assign chg_cnt = chg_cnt_reg;
  assign tick    = tick_w;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed checks of dff_pipe. Instance a uses DIV=2 and
// instance b uses DIV=1; both have WIDTH=8 and DEPTH=4.
module tb_dff_pipe;

  logic my_clk = 1'b0;
  logic rst_n;
  always #5 my_clk = ~my_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        a_sclr, a_d_valid, a_q_valid, a_tick;
  logic [7:0]  a_d, a_q;
  logic [2:0]  a_fill;
  logic [15:0] a_chg;

  logic        b_sclr, b_d_valid, b_q_valid, b_tick;
  logic [7:0]  b_d, b_q;
  logic [2:0]  b_fill;
  logic [15:0] b_chg;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .DIV(2)) dut_a (
    .my_clk (my_clk), .rst_n (rst_n), .sclr (a_sclr),
    .d (a_d), .d_valid (a_d_valid), .q (a_q), .q_valid (a_q_valid),
    .tick (a_tick), .fill (a_fill), .chg_cnt (a_chg)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(4), .DIV(1)) dut_b (
    .my_clk (my_clk), .rst_n (rst_n), .sclr (b_sclr),
    .d (b_d), .d_valid (b_d_valid), .q (b_q), .q_valid (b_q_valid),
    .tick (b_tick), .fill (b_fill), .chg_cnt (b_chg)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge my_clk);
    #1;
  endtask

  // Advance until instance a is in a tick cycle, bounded to four cycles.
  task automatic a_to_tick();
    for (int n = 0; n < 4 && !a_tick; n++) step();
    if (!a_tick) begin
      tests_run++; tests_failed++;
      $display("FAIL a_to_tick timeout: got tick=%0b want 1", a_tick);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_sclr = 1'b0; a_d = '0; a_d_valid = 1'b0;
    b_sclr = 1'b0; b_d = '0; b_d_valid = 1'b0;
    #12;
    tests_run++; if (a_q !== 8'h00) begin tests_failed++; $display("FAIL reset a_q: got %h want 00", a_q); end
    tests_run++; if (a_q_valid !== 1'b0) begin tests_failed++; $display("FAIL reset a_q_valid: got %b want 0", a_q_valid); end
    tests_run++; if (a_fill !== 3'd0) begin tests_failed++; $display("FAIL reset a_fill: got %0d want 0", a_fill); end
    tests_run++; if (a_chg !== 16'h0000) begin tests_failed++; $display("FAIL reset a_chg: got %h want 0000", a_chg); end
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL reset a_tick: got %b want 0", a_tick); end
    tests_run++; if (b_tick !== 1'b1) begin tests_failed++; $display("FAIL reset b_tick: got %b want 1", b_tick); end
    @(posedge my_clk); #1;
    rst_n = 1'b1;
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL release tick c0: got %b want 0", a_tick); end
    step();
    tests_run++; if (a_tick !== 1'b1) begin tests_failed++; $display("FAIL release tick c1: got %b want 1", a_tick); end
    step();
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL release tick c2: got %b want 0", a_tick); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill_latency();
    logic [7:0] vals [4];
    logic [7:0] exp_q;
    vals = '{8'hA5, 8'h11, 8'h22, 8'h33};
    a_sclr = 1'b1; step(); a_sclr = 1'b0;
    tests_run++; if (a_fill !== 3'd0) begin tests_failed++; $display("FAIL latency start fill: got %0d want 0", a_fill); end
    a_to_tick();
    for (int i = 0; i < 4; i++) begin
      a_d = vals[i]; a_d_valid = 1'b1;
      step();
      exp_q = (i == 3) ? 8'hA5 : 8'h00;
      tests_run++; if (a_fill !== 3'(i + 1)) begin tests_failed++; $display("FAIL latency fill t%0d: got %0d want %0d", i, a_fill, i + 1); end
      tests_run++; if (a_q !== exp_q) begin tests_failed++; $display("FAIL latency q t%0d: got %h want %h", i, a_q, exp_q); end
      tests_run++; if (a_q_valid !== (i == 3)) begin tests_failed++; $display("FAIL latency q_valid t%0d: got %b want %b", i, a_q_valid, i == 3); end
      // Off-tick edge: the garbage input must be ignored.
      a_d = 8'hFF; a_d_valid = 1'b1;
      step();
      tests_run++; if (a_fill !== 3'(i + 1)) begin tests_failed++; $display("FAIL hold fill t%0d: got %0d want %0d", i, a_fill, i + 1); end
      tests_run++; if (a_q !== exp_q) begin tests_failed++; $display("FAIL hold q t%0d: got %h want %h", i, a_q, exp_q); end
      a_to_tick();
      $display("[TB] fill_latency tick %0d d=%h q=%h fill=%0d", i, vals[i], a_q, a_fill);
    end
    tests_run++; if (a_chg !== 16'd1) begin tests_failed++; $display("FAIL latency chg: got %0d want 1", a_chg); end
  endtask

  task automatic test_sclr_on_tick();
    tests_run++; if (a_fill !== 3'd4) begin tests_failed++; $display("FAIL sclr pre fill: got %0d want 4", a_fill); end
    a_sclr = 1'b1; a_d = 8'h77; a_d_valid = 1'b1;
    step();
    a_sclr = 1'b0; a_d_valid = 1'b0;
    tests_run++; if (a_fill !== 3'd0) begin tests_failed++; $display("FAIL sclr fill: got %0d want 0", a_fill); end
    tests_run++; if (a_q !== 8'h00) begin tests_failed++; $display("FAIL sclr q: got %h want 00", a_q); end
    tests_run++; if (a_q_valid !== 1'b0) begin tests_failed++; $display("FAIL sclr q_valid: got %b want 0", a_q_valid); end
    tests_run++; if (a_chg !== 16'd0) begin tests_failed++; $display("FAIL sclr chg: got %0d want 0", a_chg); end
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL sclr tick c0: got %b want 0", a_tick); end
    step();
    tests_run++; if (a_tick !== 1'b1) begin tests_failed++; $display("FAIL sclr tick c1: got %b want 1", a_tick); end
    $display("[TB] sclr_on_tick fill=%0d q=%h", a_fill, a_q);
  endtask

  task automatic test_bubbles();
    logic [7:0] dv [7];
    logic       vv [7];
    logic [7:0] eq [7];
    logic       ev [7];
    logic [2:0] ef [7];
    dv = '{8'hC3, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    eq = '{8'h00, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h3C, 8'h00};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ef = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    for (int t = 0; t < 7; t++) begin
      a_to_tick();
      a_d = dv[t]; a_d_valid = vv[t];
      step();
      tests_run++; if (a_q !== eq[t]) begin tests_failed++; $display("FAIL bubble q t%0d: got %h want %h", t, a_q, eq[t]); end
      tests_run++; if (a_q_valid !== ev[t]) begin tests_failed++; $display("FAIL bubble q_valid t%0d: got %b want %b", t, a_q_valid, ev[t]); end
      tests_run++; if (a_fill !== ef[t]) begin tests_failed++; $display("FAIL bubble fill t%0d: got %0d want %0d", t, a_fill, ef[t]); end
      $display("[TB] bubble tick %0d d=%h v=%b q=%h qv=%b", t, dv[t], vv[t], a_q, a_q_valid);
    end
    a_d_valid = 1'b0;
    tests_run++; if (a_chg !== 16'd4) begin tests_failed++; $display("FAIL bubble chg: got %0d want 4", a_chg); end
  endtask

  task automatic test_async_reset();
    logic [7:0] dv [5];
    dv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    a_sclr = 1'b1; step(); a_sclr = 1'b0;
    for (int t = 0; t < 5; t++) begin
      a_to_tick();
      a_d = dv[t]; a_d_valid = (t < 4);
      step();
    end
    a_d_valid = 1'b0;
    tests_run++; if (a_fill !== 3'd3) begin tests_failed++; $display("FAIL areset pre fill: got %0d want 3", a_fill); end
    tests_run++; if (a_q !== 8'hBB) begin tests_failed++; $display("FAIL areset pre q: got %h want BB", a_q); end
    tests_run++; if (a_chg !== 16'd2) begin tests_failed++; $display("FAIL areset pre chg: got %0d want 2", a_chg); end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (a_q !== 8'h00) begin tests_failed++; $display("FAIL areset q: got %h want 00", a_q); end
    tests_run++; if (a_q_valid !== 1'b0) begin tests_failed++; $display("FAIL areset q_valid: got %b want 0", a_q_valid); end
    tests_run++; if (a_fill !== 3'd0) begin tests_failed++; $display("FAIL areset fill: got %0d want 0", a_fill); end
    tests_run++; if (a_chg !== 16'd0) begin tests_failed++; $display("FAIL areset chg: got %0d want 0", a_chg); end
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL areset tick: got %b want 0", a_tick); end
    @(posedge my_clk); #1;
    rst_n = 1'b1;
    tests_run++; if (a_tick !== 1'b0) begin tests_failed++; $display("FAIL areset release c0: got %b want 0", a_tick); end
    step();
    tests_run++; if (a_tick !== 1'b1) begin tests_failed++; $display("FAIL areset release c1: got %b want 1", a_tick); end
    tests_run++; if (a_fill !== 3'd0) begin tests_failed++; $display("FAIL areset release fill: got %0d want 0", a_fill); end
    $display("[TB] async_reset q=%h fill=%0d", a_q, a_fill);
  endtask

  task automatic test_div1_stream();
    int exp_q;
    b_sclr = 1'b1; step(); b_sclr = 1'b0;
    tests_run++; if (b_tick !== 1'b1) begin tests_failed++; $display("FAIL div1 tick after sclr: got %b want 1", b_tick); end
    tests_run++; if (b_fill !== 3'd0) begin tests_failed++; $display("FAIL div1 fill after sclr: got %0d want 0", b_fill); end
    for (int m = 1; m <= 10; m++) begin
      b_d = 8'(m); b_d_valid = 1'b1;
      step();
      exp_q = (m >= 4) ? m - 3 : 0;
      tests_run++; if (b_q !== 8'(exp_q)) begin tests_failed++; $display("FAIL div1 q c%0d: got %0d want %0d", m, b_q, exp_q); end
      tests_run++; if (b_q_valid !== (m >= 4)) begin tests_failed++; $display("FAIL div1 q_valid c%0d: got %b want %b", m, b_q_valid, m >= 4); end
      tests_run++; if (b_chg !== 16'(exp_q)) begin tests_failed++; $display("FAIL div1 chg c%0d: got %0d want %0d", m, b_chg, exp_q); end
      tests_run++; if (b_fill !== 3'((m < 4) ? m : 4)) begin tests_failed++; $display("FAIL div1 fill c%0d: got %0d want %0d", m, b_fill, (m < 4) ? m : 4); end
      tests_run++; if (b_tick !== 1'b1) begin tests_failed++; $display("FAIL div1 tick c%0d: got %b want 1", m, b_tick); end
      $display("[TB] div1 cycle %0d d=%0d q=%0d chg=%0d", m, m, b_q, b_chg);
    end
  endtask

  task automatic test_saturate();
    b_sclr = 1'b1; step(); b_sclr = 1'b0;
    for (int m = 1; m <= 65540; m++) begin
      b_d = m[0] ? 8'h55 : 8'hAA; b_d_valid = 1'b1;
      step();
      if (m == 100) begin
        tests_run++; if (b_chg !== 16'd97) begin tests_failed++; $display("FAIL sat chg c100: got %0d want 97", b_chg); end
      end
      if (m == 65537) begin
        tests_run++; if (b_chg !== 16'hFFFE) begin tests_failed++; $display("FAIL sat chg FFFE: got %h want FFFE", b_chg); end
      end
      if (m == 65538) begin
        tests_run++; if (b_chg !== 16'hFFFF) begin tests_failed++; $display("FAIL sat chg FFFF: got %h want FFFF", b_chg); end
      end
    end
    tests_run++; if (b_chg !== 16'hFFFF) begin tests_failed++; $display("FAIL sat chg hold: got %h want FFFF", b_chg); end
    tests_run++; if (b_q !== 8'h55) begin tests_failed++; $display("FAIL sat q: got %h want 55", b_q); end
    $display("[TB] saturate chg=%h q=%h", b_chg, b_q);
  endtask

  initial begin
    test_reset();
    test_fill_latency();
    test_sclr_on_tick();
    test_bubbles();
    test_async_reset();
    test_div1_stream();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
